// File: rtl/ofifo_drain_pkg.sv
// Shared types and SRAM control encodings for the OFIFO drain block.
package ofifo_drain_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    RDOLD = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // psum SRAM strobes are active-low
  localparam logic CEN_ON  = 1'b0;
  localparam logic CEN_OFF = 1'b1;
  localparam logic WEN_WR  = 1'b0;
  localparam logic WEN_RD  = 1'b1;

endpackage

// File: rtl/ofifo_drain_vec_add.sv
// Lane-wise wrapping adder: col independent psum_bw-bit two's-complement adds.
module psum_vec_add #(
  parameter int psum_bw = 16,
  parameter int col     = 8
) (
  input  logic [psum_bw*col-1:0] i_a,
  input  logic [psum_bw*col-1:0] i_b,
  output logic [psum_bw*col-1:0] o_sum
);

  // Each lane truncates its own carry so nothing leaks into the neighbour
  always_comb begin
    o_sum = '0;
    for (int unsigned i = 0; i < col; i++) begin
      o_sum[psum_bw*i +: psum_bw] = i_a[psum_bw*i +: psum_bw] + i_b[psum_bw*i +: psum_bw];
    end
  end

endmodule

// File: rtl/ofifo_drain.sv
// Drains psum rows from the corelet OFIFO into the psum SRAM, either
// overwriting the stored rows or accumulating into them (read-modify-write).
module ofifo_drain
  import ofifo_drain_pkg::*;
#(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int addr_w  = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   acc,
  input  logic [addr_w-1:0]      base_addr,
  input  logic [addr_w:0]        count,
  input  logic                   ofifo_valid,
  input  logic [psum_bw*col-1:0] ofifo_rdata,
  output logic                   ofifo_rd,
  output logic                   psum_cen,
  output logic                   psum_wen,
  output logic [addr_w-1:0]      psum_a,
  output logic [psum_bw*col-1:0] psum_d,
  input  logic [psum_bw*col-1:0] psum_q,
  output logic                   busy,
  output logic                   done
);

  localparam int W = psum_bw * col;

  state_t              r_state;
  logic                r_acc;
  logic [addr_w-1:0]   r_addr;
  logic [addr_w:0]     r_rem;
  logic [W-1:0]        r_row;
  logic [W-1:0]        r_sum;
  logic [addr_w-1:0]   r_a_hold;
  logic [W-1:0]        r_d_hold;
  logic                r_busy;
  logic                r_done;

  logic [W-1:0]        w_sum;
  logic [W-1:0]        w_wdata;
  logic                w_rd_acc;
  logic                w_wr;
  logic                w_access;

  psum_vec_add #(
    .psum_bw (psum_bw),
    .col     (col)
  ) u_add (
    .i_a   (r_row),
    .i_b   (psum_q),
    .o_sum (w_sum)
  );

  // Decode of the cycles that touch the SRAM
  always_comb begin
    w_rd_acc = (r_state == WAIT) && r_acc && ofifo_valid;
    w_wr     = (r_state == WRITE);
    w_access = w_rd_acc || w_wr;
    w_wdata  = r_acc ? r_sum : r_row;
  end

  // Control sequencer: latch the job on start, then pop/read/write one row at a time
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_acc    <= 1'b0;
      r_addr   <= '0;
      r_rem    <= '0;
      r_row    <= '0;
      r_sum    <= '0;
      r_a_hold <= '0;
      r_d_hold <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc  <= acc;
            r_addr <= base_addr;
            r_rem  <= count;
            r_busy <= 1'b1;
            if (count == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (ofifo_valid) begin
            r_row <= ofifo_rdata;
            if (r_acc) begin
              r_a_hold <= r_addr;
              r_state  <= RDOLD;
            end else begin
              r_state  <= WRITE;
            end
          end
        end
        RDOLD: begin
          r_sum   <= w_sum;
          r_state <= WRITE;
        end
        WRITE: begin
          r_a_hold <= r_addr;
          r_d_hold <= w_wdata;
          r_addr   <= r_addr + 1'b1;
          r_rem    <= r_rem - 1'b1;
          if (r_rem == (addr_w+1)'(1)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= WAIT;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // The accumulate read must issue in the same cycle the row is popped, so the
  // strobes are decoded from state; address/data fall back to held copies so
  // they keep their last driven value between accesses.
  always_comb begin
    ofifo_rd = (r_state == WAIT) && ofifo_valid;
    psum_cen = w_access ? CEN_ON : CEN_OFF;
    psum_wen = w_wr ? WEN_WR : WEN_RD;
    psum_a   = w_access ? r_addr : r_a_hold;
    psum_d   = w_wr ? w_wdata : r_d_hold;
    busy     = r_busy;
    done     = r_done;
  end

endmodule

// File: tb/tb_ofifo_drain.sv
// Bench for ofifo_drain: behavioural OFIFO and SRAM, queue-based reference of
// expected SRAM writes, pops and cycle timing.
module tb_ofifo_drain;

  localparam int PBW = 16;
  localparam int COL = 8;
  localparam int AW  = 11;
  localparam int W   = PBW * COL;

  logic          clk = 1'b0;
  logic          reset, start, acc;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic          ofifo_valid, ofifo_rd;
  logic [W-1:0]  ofifo_rdata;
  logic          psum_cen, psum_wen;
  logic [AW-1:0] psum_a;
  logic [W-1:0]  psum_d, psum_q;
  logic          busy, done;

  always #5 clk = ~clk;

  ofifo_drain #(.psum_bw(PBW), .col(COL), .addr_w(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .acc(acc),
    .base_addr(base_addr), .count(count),
    .ofifo_valid(ofifo_valid), .ofifo_rdata(ofifo_rdata), .ofifo_rd(ofifo_rd),
    .psum_cen(psum_cen), .psum_wen(psum_wen), .psum_a(psum_a),
    .psum_d(psum_d), .psum_q(psum_q), .busy(busy), .done(done)
  );

  // SRAM model (1-cycle read latency) with a bench-side preload port
  logic [W-1:0]  mem [0:(1<<AW)-1];
  logic          pl_en;
  logic [AW-1:0] pl_a;
  logic [W-1:0]  pl_d;
  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (!psum_cen) begin
      if (!psum_wen) mem[psum_a] <= psum_d;
      else           psum_q      <= mem[psum_a];
    end
  end

  // Bench state
  logic [W-1:0]  fq[$];
  logic [W-1:0]  rows_in[$];
  logic [W-1:0]  exp_mem[int];
  logic          gate;
  bit            gate_log[int];
  logic [AW-1:0] wr_a[$], rd_a[$];
  logic [W-1:0]  wr_d[$];
  int            wr_c[$], rd_c[$], done_c[$];
  int            n_pop, n_busy, cyc;
  int            n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic update_pins();
    ofifo_valid = gate && (fq.size() > 0);
    ofifo_rdata = (fq.size() > 0) ? fq[0] : '0;
  endtask

  // One clock: log mid-cycle, then apply the pop after the edge
  task automatic tick();
    bit pop_now;
    update_pins();
    @(negedge clk);
    if (!psum_cen && !psum_wen) begin wr_a.push_back(psum_a); wr_d.push_back(psum_d); wr_c.push_back(cyc); end
    if (!psum_cen &&  psum_wen) begin rd_a.push_back(psum_a); rd_c.push_back(cyc); end
    if (done) done_c.push_back(cyc);
    if (busy) n_busy++;
    pop_now = ofifo_rd;
    if (ofifo_rd) n_pop++;
    @(posedge clk);
    #1;
    cyc++;
    if (pop_now && fq.size() > 0) void'(fq.pop_front());
    update_pins();
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
    pl_a = a; pl_d = d; pl_en = 1'b1;
    tick();
    pl_en = 1'b0;
    exp_mem[int'(a)] = d;
  endtask

  function automatic logic [W-1:0] rand_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference lane arithmetic: independent sums modulo 2^PBW
  function automatic logic [W-1:0] lane_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    int s;
    r = '0;
    for (int i = 0; i < COL; i++) begin
      s = (int'(x[PBW*i +: PBW]) + int'(y[PBW*i +: PBW])) % (1 << PBW);
      r[PBW*i +: PBW] = PBW'(s);
    end
    return r;
  endfunction

  task automatic clear_logs();
    wr_a.delete(); wr_d.delete(); wr_c.delete();
    rd_a.delete(); rd_c.delete(); done_c.delete();
    n_pop = 0; n_busy = 0; gate_log.delete();
  endtask

  // Run one drain of rows_in and check writes, reads, pops and timing
  task automatic do_drain(input string nm, input bit a_mode, input logic [AW-1:0] base,
                          input int cnt, input int gap, input bit stall, input bit restart);
    logic [AW-1:0] ew_a[$];
    logic [W-1:0]  ew_d[$];
    logic [AW-1:0] a;
    logic [W-1:0]  cur;
    int S, t, p, gap_used, done_exp;
    bit seen;
    clear_logs();
    for (int i = 0; i < cnt; i++) begin
      a = base + AW'(i);
      cur = a_mode ? lane_add(exp_mem[int'(a)], rows_in[i]) : rows_in[i];
      exp_mem[int'(a)] = cur;
      ew_a.push_back(a); ew_d.push_back(cur);
    end
    foreach (rows_in[i]) fq.push_back(rows_in[i]);
    fq.push_back(rand_row());
    acc = a_mode; base_addr = base; count = (AW+1)'(cnt); start = 1'b1;
    gate = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    S = cyc; gate_log[cyc] = gate;
    tick();
    start = 1'b0; base_addr = ~base; count = (AW+1)'($urandom_range(1, 9)); acc = ~a_mode;
    gap_used = 0; seen = 0;
    for (int k = 0; k < cnt*3 + 200 && !seen; k++) begin
      if (gap > 0 && n_pop >= 1 && gap_used < gap) begin gate = 1'b0; gap_used++; end
      else if (stall) gate = 1'($urandom_range(0, 1));
      else gate = 1'b1;
      if (restart) begin start = 1'b1; base_addr = base ^ 11'h155; count = 12'd5; end
      gate_log[cyc] = gate;
      tick();
      start = 1'b0;
      if (done_c.size() > 0) seen = 1;
    end
    chk({nm, "_done_seen"}, W'(seen), W'(1));
    gate = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    // Timing reference: pop on first gated-high cycle once waiting, write 1 (or 2) later
    t = S + 1;
    for (int i = 0; i < cnt; i++) begin
      p = t;
      while (!(gate_log.exists(p) && gate_log[p]) && p < t + 1000) p++;
      if (a_mode) begin
        chk({nm, "_rd_a"}, W'((i < rd_a.size()) ? rd_a[i] : 'x), W'(ew_a[i]));
        chk({nm, "_rd_cyc"}, W'((i < rd_c.size()) ? rd_c[i] : -1), W'(p));
      end
      t = p + (a_mode ? 2 : 1);
      chk({nm, "_wr_a"}, W'((i < wr_a.size()) ? wr_a[i] : 'x), W'(ew_a[i]));
      chk({nm, "_wr_d"}, (i < wr_d.size()) ? wr_d[i] : 'x, ew_d[i]);
      chk({nm, "_wr_cyc"}, W'((i < wr_c.size()) ? wr_c[i] : -1), W'(t));
      t = t + 1;
    end
    done_exp = t;
    chk({nm, "_n_wr"}, W'(wr_a.size()), W'(cnt));
    chk({nm, "_n_rd"}, W'(rd_a.size()), W'(a_mode ? cnt : 0));
    chk({nm, "_n_pop"}, W'(n_pop), W'(cnt));
    chk({nm, "_left"}, W'(fq.size()), W'(1));
    chk({nm, "_n_done"}, W'(done_c.size()), W'(1));
    chk({nm, "_done_cyc"}, W'((done_c.size() > 0) ? done_c[0] : -1), W'(done_exp));
    chk({nm, "_busy_cyc"}, W'(n_busy), W'(done_exp - S));
    fq.delete();
    update_pins();
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_rd"},   W'(ofifo_rd), W'(0));
    chk({nm, "_cen"},  W'(psum_cen), W'(1));
    chk({nm, "_wen"},  W'(psum_wen), W'(1));
    chk({nm, "_a"},    W'(psum_a),   W'(0));
    chk({nm, "_d"},    psum_d,       W'(0));
    chk({nm, "_busy"}, W'(busy),     W'(0));
    chk({nm, "_done"}, W'(done),     W'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] rb;
    int rc;
    bit ra;
    reset = 1'b0; start = 1'b0; acc = 1'b0; base_addr = '0; count = '0;
    gate = 1'b1; pl_en = 1'b0; pl_a = '0; pl_d = '0; cyc = 0;
    fq.push_back(rand_row());
    update_pins();
    #1;
    check_reset_outputs("rst0");
    tick(); tick();
    check_reset_outputs("rst1");
    fq.delete();
    reset = 1'b1;
    tick();

    // Overwrite run
    rows_in.delete();
    for (int i = 0; i < 3; i++) rows_in.push_back(rand_row());
    do_drain("ovw", 1'b0, 11'h010, 3, 0, 1'b0, 1'b0);

    // Accumulate 5 + 3
    preload(11'h020, {COL{16'h0005}});
    rows_in.delete(); rows_in.push_back({COL{16'h0003}});
    do_drain("acc", 1'b1, 11'h020, 1, 0, 1'b0, 1'b0);
    chk("acc_const", (wr_d.size() > 0) ? wr_d[0] : 'x, {COL{16'h0008}});

    // Lane wrap without carry leaking into neighbours
    preload(11'h030, {16'h8888, 16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h1111, 16'hFFFF, 16'h7FFF});
    rows_in.delete(); rows_in.push_back({96'h0, 16'h0001, 16'h0001});
    do_drain("wrap", 1'b1, 11'h030, 1, 0, 1'b0, 1'b0);
    chk("wrap_const", (wr_d.size() > 0) ? wr_d[0] : 'x,
        {16'h8888, 16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h1111, 16'h0000, 16'h8000});

    // Stall of 5 cycles plus address wrap
    rows_in.delete();
    for (int i = 0; i < 2; i++) rows_in.push_back(rand_row());
    do_drain("stall", 1'b0, 11'h7FF, 2, 5, 1'b0, 1'b0);
    chk("stall_a0", W'((wr_a.size() > 0) ? wr_a[0] : 'x), W'(11'h7FF));
    chk("stall_a1", W'((wr_a.size() > 1) ? wr_a[1] : 'x), W'(11'h000));

    // count = 0
    rows_in.delete();
    do_drain("zero", 1'b0, 11'h100, 0, 0, 1'b0, 1'b0);

    // start held high through the drain and the DONE cycle
    for (int i = 0; i < 3; i++) rows_in.push_back(rand_row());
    do_drain("restart", 1'b0, 11'h200, 3, 0, 1'b0, 1'b1);

    // Reset while in RDOLD
    rows_in.delete(); clear_logs();
    for (int i = 0; i < 2; i++) begin
      preload(11'h040 + AW'(i), rand_row());
      fq.push_back(rand_row());
    end
    clear_logs();
    acc = 1'b1; base_addr = 11'h040; count = 12'd2; start = 1'b1; gate = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20 && rd_c.size() == 0; k++) tick();
    chk("rdold_read_seen", W'(rd_c.size()), W'(1));
    reset = 1'b0;
    #1;
    check_reset_outputs("rdold_rst");
    tick(); tick(); tick();
    chk("rdold_no_wr", W'(wr_a.size()), W'(0));
    chk("rdold_pops", W'(n_pop), W'(1));
    reset = 1'b1;
    fq.delete(); update_pins();
    tick();
    rows_in.delete();
    for (int i = 0; i < 2; i++) begin
      preload(11'h050 + AW'(i), rand_row());
      rows_in.push_back(rand_row());
    end
    do_drain("after_rst", 1'b1, 11'h050, 2, 0, 1'b0, 1'b0);

    // Randomized drains with random OFIFO valid gaps
    for (int n = 0; n < 8; n++) begin
      ra = 1'($urandom_range(0, 1));
      rb = AW'($urandom);
      rc = $urandom_range(1, 5);
      rows_in.delete();
      for (int i = 0; i < rc; i++) begin
        if (ra) preload(rb + AW'(i), rand_row());
        rows_in.push_back(rand_row());
      end
      do_drain("rand", ra, rb, rc, 0, 1'b1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
